// File: rtl/twos_comp_to_sign_mag.sv
// Bit-serial two's-complement to sign-magnitude converter.
// Converts one bit per clock, LSB first, using the copy-up-to-first-one-then-invert
// rule. Valid/ready handshakes are used on both the input and the output side.
module twos_comp_to_sign_mag #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_ovf
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               seen_one_q, seen_one_d;
  logic               out_sign_q, out_sign_d;
  logic [WIDTH-1:0]   out_mag_q, out_mag_d;
  logic               out_ovf_q, out_ovf_d;
  logic               cur_bit;

  // Handshake outputs derive from state; in_ready is also held low during reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;
  assign out_ovf   = out_ovf_q;

  // Next-state and datapath update for the serial conversion.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    idx_d      = idx_q;
    seen_one_d = seen_one_q;
    out_sign_d = out_sign_q;
    out_mag_d  = out_mag_q;
    out_ovf_d  = out_ovf_q;
    cur_bit    = data_q[idx_q];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = in_data;
          out_sign_d = in_data[WIDTH-1];
          out_ovf_d  = (in_data == MOST_NEG);
          out_mag_d  = '0;
          idx_d      = '0;
          seen_one_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        // Negative words: bits up to and including the first 1 pass, later bits invert.
        out_mag_d[idx_q] = (out_sign_q && seen_one_q) ? ~cur_bit : cur_bit;
        seen_one_d       = seen_one_q | cur_bit;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      idx_q      <= '0;
      seen_one_q <= 1'b0;
      out_sign_q <= 1'b0;
      out_mag_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      seen_one_q <= seen_one_d;
      out_sign_q <= out_sign_d;
      out_mag_q  <= out_mag_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: doc/twos_comp_to_sign_mag.md
# twos_comp_to_sign_mag

Bit-serial converter that takes a WIDTH-bit two's-complement word and returns its sign-magnitude form: sign bit, unsigned magnitude, and an overflow flag for the most-negative value. It is the decode side of the team's two's-complement arithmetic blocks, where words from a negator/ALU datapath are turned back into human-readable sign/magnitude for display or checking. Input and output use valid/ready handshakes. The conversion is a multi-cycle FSM, one bit per clock, LSB first.

## Interface
- WIDTH, 4, word width in bits (legal range ≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data holds a word to convert.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  two's-complement operand.
- out_valid  output  1  result registers hold a finished conversion.
- out_ready  input  1  consumer takes the result this cycle.
- out_sign  output  1  sign of result (1 = negative).
- out_mag  output  WIDTH  unsigned magnitude, |in_data|.
- out_ovf  output  1  input was 1000…0; its magnitude 2^(WIDTH-1) is not representable in WIDTH-bit sign-magnitude.

## Operation
- States: IDLE, CONV, DONE.
- Internal registers: data, bit counter idx of width clog2(WIDTH), seen_one flag.
- IDLE
  - in_ready = 1 and out_valid = 0.
  - On in_valid && in_ready: capture data = in_data, out_sign = in_data[WIDTH-1], out_ovf = (in_data == {1'b1, {WIDTH-1{1'b0}}}).
  - Also on accept: out_mag = 0, idx = 0, seen_one = 0, then go to CONV.
- CONV: each cycle processes bit b = data[idx].
  - If out_sign = 0: out_mag[idx] = b.
  - If out_sign = 1: out_mag[idx] = seen_one ? ~b : b. This is the copy-up-to-first-1-then-invert rule.
  - seen_one |= b.
  - When idx == WIDTH-1, go to DONE. Otherwise idx increments.
- DONE
  - out_valid = 1.
  - out_sign, out_mag and out_ovf are held stable until out_valid && out_ready, then go to IDLE.
- in_ready = (state == IDLE) && !rst. Inputs presented while in_ready = 0 are ignored, not queued.
- in_data is sampled only at the accept edge. Later changes to in_data do not affect the conversion in flight.
- Overflow case 1000…0 produces out_sign = 1, out_mag = 1000…0, out_ovf = 1. The magnitude is correct as an unsigned value.
- Zero input produces sign 0, magnitude 0, ovf 0.
- out_mag is only meaningful while out_valid = 1. During CONV it holds partial bits.

## Timing
- Reset: while rst is sampled high, next state is IDLE.
  - All outputs reset to 0: in_ready 0, out_valid 0, out_sign 0, out_mag 0, out_ovf 0.
  - in_ready rises in the first cycle after rst is low.
- Reset mid-CONV or in DONE: the conversion is discarded with no out_valid pulse, and the block returns to IDLE.
- Latency:
  - The accept edge is E0.
  - The bits are converted on edges E1…E_WIDTH.
  - out_valid is high after E_WIDTH, i.e. WIDTH cycles after acceptance.
- If out_ready is already high when out_valid rises, the handshake completes on that edge, so out_valid lasts one cycle.
- In the handshake cycle in DONE, in_ready = 0. The next word can be accepted at the earliest one cycle later in IDLE.
- Maximum throughput is one word per WIDTH+2 cycles.
- Backpressure: with out_ready low, DONE is held indefinitely, in_ready stays 0, and outputs stay stable.
- There is no combinational path from in_* to out_* or from out_ready to in_ready.

## Test plan
All scenarios use WIDTH = 4.
- Reset: assert rst for 2 cycles mid-stream, then release. All outputs are 0 during reset, and in_ready = 1 in the first cycle after release.
- Positive value: in_data = 0101 → after 4 cycles out_valid = 1, out_sign = 0, out_mag = 0101, out_ovf = 0. With out_ready = 1 the pulse lasts 1 cycle.
- Negative values:
  - in_data = 1011 → sign 1, mag 0101.
  - in_data = 1111 → sign 1, mag 0001.
  - in_data = 1100 → sign 1, mag 0100.
  - All have ovf 0.
- Boundaries:
  - in_data = 1000 → sign 1, mag 1000, ovf 1.
  - in_data = 0000 → sign 0, mag 0000, ovf 0.
- Backpressure and ignored input: hold out_ready low 5 cycles after out_valid. Outputs stay constant and in_ready stays 0. in_valid with 0111 during this window is ignored. After out_ready, the next accept happens one cycle later.
- Reset during CONV, then exhaustive sweep:
  - Assert rst 2 cycles after accepting 1001. No out_valid appears and the block returns to IDLE.
  - Then sweep all 16 inputs back-to-back with the in/out handshakes. Each result matches the reference |x| and sign.
